// File: rtl/apu_length_counter_bank.sv
// Bank of CHANNELS APU length counters sharing one half-frame strobe and one length-table index.
// Optional build macro: APU_LEN_RELOAD_RACE_EN (a load landing on the strobe reloads only an empty counter).
package apu_len_pkg;

  typedef struct packed {
    logic en;
    logic halt;
    logic load;
  } lane_req_t;

  typedef struct packed {
    logic act;
    logic gate;
  } lane_rsp_t;

  function automatic logic [7:0] len_table(input logic [4:0] i);
    logic [7:0] v;
    case (i)
      5'd0:  v = 8'd10;
      5'd1:  v = 8'd254;
      5'd2:  v = 8'd20;
      5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;
      5'd5:  v = 8'd4;
      5'd6:  v = 8'd80;
      5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;
      5'd9:  v = 8'd8;
      5'd10: v = 8'd60;
      5'd11: v = 8'd10;
      5'd12: v = 8'd14;
      5'd13: v = 8'd12;
      5'd14: v = 8'd26;
      5'd15: v = 8'd14;
      5'd16: v = 8'd12;
      5'd17: v = 8'd16;
      5'd18: v = 8'd24;
      5'd19: v = 8'd18;
      5'd20: v = 8'd48;
      5'd21: v = 8'd20;
      5'd22: v = 8'd96;
      5'd23: v = 8'd22;
      5'd24: v = 8'd192;
      5'd25: v = 8'd24;
      5'd26: v = 8'd72;
      5'd27: v = 8'd26;
      5'd28: v = 8'd16;
      5'd29: v = 8'd28;
      5'd30: v = 8'd32;
      default: v = 8'd30;
    endcase
    return v;
  endfunction

endpackage

module apu_len_lane
  import apu_len_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       hframe,
  input  logic [4:0] idx,
  input  lane_req_t  req,
  output lane_rsp_t  rsp
);

  logic [CNT_W-1:0] cnt;
  logic             pend;
  logic [4:0]       pend_idx;
  logic             gate;
  logic             cnt_nz;
  logic             take_load;
  logic             reload;
  logic [4:0]       sel_idx;
  logic [CNT_W-1:0] tbl_val;

  assign cnt_nz = |cnt;

`ifdef APU_LEN_RELOAD_RACE_EN
  // write landing on the clock edge is lost unless the counter was already empty
  assign take_load = req.load & ~cnt_nz;
`else
  assign take_load = req.load;
`endif

  assign reload  = pend | take_load;
  assign sel_idx = take_load ? idx : pend_idx;
  assign tbl_val = CNT_W'(len_table(sel_idx));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt      <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      gate     <= 1'b0;
    end else if (!req.en) begin
      cnt  <= '0;
      pend <= 1'b0;
      gate <= 1'b0;
    end else if (hframe) begin
      gate <= cnt_nz;
      pend <= 1'b0;
      if (reload)
        cnt <= tbl_val;
      else if (!req.halt && cnt_nz)
        cnt <= cnt - CNT_W'(1);
    end else if (req.load) begin
      pend     <= 1'b1;
      pend_idx <= idx;
    end
  end

  assign rsp.act  = cnt_nz;
  assign rsp.gate = gate;

endmodule

module apu_length_counter_bank
  import apu_len_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8   // must be >= 8 so every table entry fits
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                hframe,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] halt,
  input  logic [CHANNELS-1:0] load,
  input  logic [4:0]          idx,
  output logic [CHANNELS-1:0] act,
  output logic [CHANNELS-1:0] gate
);

  lane_req_t req [CHANNELS];
  lane_rsp_t rsp [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign req[i] = '{en: en[i], halt: halt[i], load: load[i]};

    apu_len_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .n_reset (n_reset),
      .hframe  (hframe),
      .idx     (idx),
      .req     (req[i]),
      .rsp     (rsp[i])
    );

    assign act[i]  = rsp[i].act;
    assign gate[i] = rsp[i].gate;
  end

endmodule

// File: tb/tb_apu_length_counter_bank.sv
// Directed bench for apu_length_counter_bank; counter values are measured by counting strobes to empty.
module tb_apu_length_counter_bank;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          hframe;
  logic [CH-1:0] en, halt, load;
  logic [4:0]    idx;
  logic [CH-1:0] act, gate;

  int total = 0;
  int bad   = 0;
  int n;

  apu_length_counter_bank #(.CHANNELS(CH), .CNT_W(8)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .hframe  (hframe),
    .en      (en),
    .halt    (halt),
    .load    (load),
    .idx     (idx),
    .act     (act),
    .gate    (gate)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic hf();
    hframe = 1'b1;
    clk1();
    hframe = 1'b0;
  endtask

  task automatic ld(input int ch, input logic [4:0] ix);
    load[ch] = 1'b1;
    idx      = ix;
    clk1();
    load = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // strobe until the channel empties; the strobe count equals the counter value
  task automatic drain(input int ch, output int cnt);
    cnt = 0;
    while (act[ch] && cnt < 400) begin
      hf();
      cnt++;
    end
  endtask

  initial begin
    n_reset = 1'b0;
    hframe  = 1'b1;
    en      = '1;
    halt    = '0;
    load    = '1;
    idx     = 5'd1;
    clk1();
    clk1();
    chk("reset_act", act, 0);
    chk("reset_gate", gate, 0);
    n_reset = 1'b1;
    hframe  = 1'b0;
    load    = '0;
    hf();
    chk("post_reset_act", act, 0);
    chk("post_reset_gate", gate, 0);

    // basic load and decrement
    ld(0, 5'd1);
    chk("ld0_before_hf", act, 0);
    hf();
    chk("ld0_act", act, 4'b0001);
    chk("ld0_gate_pre", gate, 0);
    hf(); hf(); hf();
    chk("ld0_gate", gate, 4'b0001);
    drain(0, n);
    chk("ld0_cnt251", n, 251);
    chk("ld0_gate_last", gate[0], 1);
    hf();
    chk("ld0_gate_off", gate[0], 0);

    // halt holds the count, no wrap below zero
    ld(1, 5'd3);
    hf();
    chk("h1_act", act[1], 1);
    halt[1] = 1'b1;
    repeat (5) hf();
    chk("h1_held", act[1], 1);
    halt[1] = 1'b0;
    halt[0] = 1'b1;
    clk1();
    halt[0] = 1'b0;
    hf();
    chk("h1_cnt1", act[1], 1);
    hf();
    chk("h1_empty", act[1], 0);
    chk("h1_gate_last", gate[1], 1);
    hf();
    chk("h1_gate_off", gate[1], 0);
    repeat (3) hf();
    chk("h1_nowrap", act, 0);

    // disable clears counter and drops requests
    ld(2, 5'd2);
    hf();
    chk("d2_act", act[2], 1);
    en[2] = 1'b0;
    clk1();
    chk("d2_cleared", act[2], 0);
    ld(2, 5'd5);
    en[2] = 1'b1;
    hf();
    chk("d2_ld_while_off", act[2], 0);
    ld(2, 5'd2);
    en[2] = 1'b0;
    clk1();
    en[2] = 1'b1;
    hf();
    chk("d2_pend_lost", act[2], 0);

    // last index before the strobe wins
    ld(3, 5'd0);
    ld(3, 5'd4);
    hf();
    chk("lw3_act", act, 4'b1000);
    drain(3, n);
    chk("lw3_cnt40", n, 40);

    // load coincident with the strobe, counter nonzero
    ld(0, 5'd7);
    hf();
    hf();
    load[0] = 1'b1;
    idx     = 5'd2;
    hf();
    load    = '0;
    drain(0, n);
`ifdef APU_LEN_RELOAD_RACE_EN
    chk("race_nz", n, 4);
`else
    chk("race_nz", n, 20);
`endif

    // coincident load with counter empty always reloads
    load[0] = 1'b1;
    idx     = 5'd2;
    hf();
    load    = '0;
    drain(0, n);
    chk("race_z", n, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
